// File: rtl/ps2_tx.sv
// rtl/ps2_tx.sv - PS/2 host-to-device command transmitter; PS2_TX_RETRY_EN enables two silent retries on NAK/timeout.
module ps2_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);
    localparam int MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] INHIBIT_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, INHIBIT, START, DATA, PARITY, STOP, WAIT_IDLE
    } state_t;

    state_t        state, state_nxt;
    logic          clk_s1, clk_s2, clk_s3, data_s1, data_s2;
    logic          fe;
    logic [CW-1:0] cnt;
    logic [7:0]    tx_byte;
    logic          parity;
    logic [2:0]    bitcnt;
    logic          nak;
    logic          accept, waiting, bus_idle;
    logic          attempt_end, timeout_hit, attempt_fail, retry_ok;

    // Sync flops idle high so reset never fabricates a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            clk_s3  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= ps2_clk_in;
            clk_s2  <= clk_s1;
            clk_s3  <= clk_s2;
            data_s1 <= ps2_data_in;
            data_s2 <= data_s1;
        end
    end

    assign fe           = clk_s3 & ~clk_s2;
    assign accept       = (state == IDLE) && tx_valid;
    assign waiting      = state inside {START, DATA, PARITY, STOP, WAIT_IDLE};
    assign bus_idle     = clk_s2 && data_s2;
    assign attempt_end  = (state == WAIT_IDLE) && bus_idle;
    // A bus release on the last allowed cycle still counts as completion.
    assign timeout_hit  = waiting && !fe && !attempt_end && (cnt == TIMEOUT_LAST);
    assign attempt_fail = timeout_hit || (attempt_end && nak);

`ifdef PS2_TX_RETRY_EN
    logic [1:0] retries;

    assign retry_ok = (retries != 2'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retries <= 2'd0;
        end else if (accept) begin
            retries <= 2'd0;
        end else if (attempt_fail && retry_ok) begin
            retries <= retries + 2'd1;
        end
    end
`else
    assign retry_ok = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (tx_valid) state_nxt = INHIBIT;
            INHIBIT:   if (cnt == INHIBIT_LAST) state_nxt = START;
            START:     if (fe) state_nxt = DATA;
            DATA:      if (fe && bitcnt == 3'd7) state_nxt = PARITY;
            PARITY:    if (fe) state_nxt = STOP;
            STOP:      if (fe) state_nxt = WAIT_IDLE;
            WAIT_IDLE: if (attempt_end) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
        if (attempt_fail) begin
            state_nxt = retry_ok ? INHIBIT : IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            tx_byte <= 8'h00;
            parity  <= 1'b0;
            bitcnt  <= 3'd0;
            nak     <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
        end else begin
            done  <= attempt_end && !nak;
            error <= attempt_fail && !retry_ok;
            if (accept) begin
                tx_byte <= tx_data;
                parity  <= ~^tx_data;
                bitcnt  <= 3'd0;
                nak     <= 1'b0;
                cnt     <= '0;
            end else if (attempt_fail) begin
                cnt    <= '0;
                bitcnt <= 3'd0;
                nak    <= 1'b0;
            end else begin
                case (state)
                    INHIBIT:                          cnt <= (cnt == INHIBIT_LAST) ? '0 : cnt + CW'(1);
                    START, DATA, PARITY, STOP, WAIT_IDLE: cnt <= fe ? '0 : cnt + CW'(1);
                    default:                          cnt <= '0;
                endcase
                if (state == DATA && fe) begin
                    bitcnt <= bitcnt + 3'd1;
                end
                // Device pulls data low during the extra clock to acknowledge.
                if (state == STOP && fe) begin
                    nak <= data_s2;
                end
            end
        end
    end

    always_comb begin
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        case (state)
            INHIBIT: ps2_clk_oe  = 1'b1;
            START:   ps2_data_oe = 1'b1;
            DATA:    ps2_data_oe = ~tx_byte[bitcnt];
            PARITY:  ps2_data_oe = ~parity;
            default: ;
        endcase
    end

    assign tx_ready = (state == IDLE);
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_ps2_tx.sv
// tb/tb_ps2_tx.sv - self-checking bench for ps2_tx with an open-drain PS/2 device model and frame scoreboard.
module tb_ps2_tx;
    localparam int INH = 100;
    localparam int TMO = 1000;
    localparam int HALF = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, done, error;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk_line, ps2_data_line;

    int n_checks = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    logic [10:0] exp_q[$];

    assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

    ps2_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .busy(busy), .done(done), .error(error),
        .ps2_clk_in(ps2_clk_line), .ps2_data_in(ps2_data_line),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (error) err_cnt++;
        if (done && error) both_cnt++;
    end

    function automatic logic [10:0] frame_of(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit push);
        int n = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        while (!tx_ready && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        tx_valid = 1'b0;
        if (push) exp_q.push_back(frame_of(b));
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL accept_busy byte=%02h got=%b want=1", b, busy); end
    endtask

    // Device: measures inhibit, records start bit at host release, then clocks npulses bits.
    task automatic device_frame(input bit ack, input int npulses, output logic [10:0] obs, output int inh);
        int n = 0;
        obs = '1;
        inh = 0;
        while (!ps2_clk_oe && n < 3000) begin @(negedge clk); n++; end
        while (ps2_clk_oe && n < 6000) begin inh++; @(negedge clk); n++; end
        obs[0] = ps2_data_line;
        repeat (10) @(negedge clk);
        for (int i = 1; i <= npulses; i++) begin
            if (i == 11 && ack) begin dev_data_low = 1'b1; repeat (5) @(negedge clk); end
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            if (i <= 10) obs[i] = ps2_data_line;
            dev_clk_low = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        dev_data_low = 1'b0;
    endtask

    task automatic wait_result(input int d0, input int e0);
        for (int i = 0; i < 300 && done_cnt == d0 && err_cnt == e0; i++) @(negedge clk);
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_checks += 6;
        if (tx_ready !== 1'b1)    begin n_fail++; $display("FAIL reset_tx_ready got=%b want=1", tx_ready); end
        if (busy !== 1'b0)        begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
        if (done !== 1'b0)        begin n_fail++; $display("FAIL reset_done got=%b want=0", done); end
        if (error !== 1'b0)       begin n_fail++; $display("FAIL reset_error got=%b want=0", error); end
        if (ps2_clk_oe !== 1'b0)  begin n_fail++; $display("FAIL reset_clk_oe got=%b want=0", ps2_clk_oe); end
        if (ps2_data_oe !== 1'b0) begin n_fail++; $display("FAIL reset_data_oe got=%b want=0", ps2_data_oe); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_ack(input logic [7:0] b);
        logic [10:0] obs, exp;
        int inh, d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        send_byte(b, 1'b1);
        device_frame(1'b1, 11, obs, inh);
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 11'h7ff;
        wait_result(d0, e0);
        n_checks += 5;
        if (inh != INH)            begin n_fail++; $display("FAIL inhibit_len byte=%02h got=%0d want=%0d", b, inh, INH); end
        if (obs !== exp)           begin n_fail++; $display("FAIL frame byte=%02h got=%b want=%b", b, obs, exp); end
        if (done_cnt - d0 != 1)    begin n_fail++; $display("FAIL done_pulses byte=%02h got=%0d want=1", b, done_cnt - d0); end
        if (err_cnt - e0 != 0)     begin n_fail++; $display("FAIL error_pulses byte=%02h got=%0d want=0", b, err_cnt - e0); end
        if (tx_ready !== 1'b1)     begin n_fail++; $display("FAIL ready_after byte=%02h got=%b want=1", b, tx_ready); end
    endtask

    task automatic test_nak;
        logic [10:0] obs, exp;
        int inh, d0, e0, attempts;
`ifdef PS2_TX_RETRY_EN
        attempts = 3;
`else
        attempts = 1;
`endif
        d0 = done_cnt; e0 = err_cnt;
        send_byte(8'hFF, 1'b0);
        for (int a = 0; a < attempts; a++) begin
            exp_q.push_back(frame_of(8'hFF));
            device_frame(1'b0, 11, obs, inh);
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : 11'h7ff;
            n_checks += 2;
            if (obs !== exp)   begin n_fail++; $display("FAIL nak_frame attempt=%0d got=%b want=%b", a, obs, exp); end
            if (a < attempts - 1 && err_cnt != e0) begin n_fail++; $display("FAIL nak_early_error attempt=%0d got=%0d want=0", a, err_cnt - e0); end
            else if (a == attempts - 1 && busy !== 1'b0) begin n_fail++; $display("FAIL nak_busy_end got=%b want=0", busy); end
        end
        wait_result(d0, e0);
        n_checks += 2;
        if (err_cnt - e0 != 1)  begin n_fail++; $display("FAIL nak_error_pulses got=%0d want=1", err_cnt - e0); end
        if (done_cnt - d0 != 0) begin n_fail++; $display("FAIL nak_done_pulses got=%0d want=0", done_cnt - d0); end
    endtask

    task automatic test_timeout;
        int n = 0, k = 0, e0;
        e0 = err_cnt;
        send_byte(8'hAB, 1'b0);
        while (!ps2_clk_oe && n < 500) begin @(negedge clk); n++; end
        while (ps2_clk_oe && n < 500) begin @(negedge clk); n++; end
`ifdef PS2_TX_RETRY_EN
        while (!error && !ps2_clk_oe && k < TMO + 100) begin @(negedge clk); k++; end
        n_checks += 2;
        if (k != TMO)       begin n_fail++; $display("FAIL timeout_retry_cycles got=%0d want=%0d", k, TMO); end
        if (err_cnt != e0)  begin n_fail++; $display("FAIL timeout_retry_error got=%0d want=0", err_cnt - e0); end
        for (int i = 0; i < 3 * (TMO + INH) && err_cnt == e0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
`else
        while (!error && k < TMO + 100) begin @(negedge clk); k++; end
        n_checks += 3;
        if (k != TMO)             begin n_fail++; $display("FAIL timeout_cycles got=%0d want=%0d", k, TMO); end
        if (ps2_clk_oe !== 1'b0)  begin n_fail++; $display("FAIL timeout_clk_oe got=%b want=0", ps2_clk_oe); end
        if (ps2_data_oe !== 1'b0) begin n_fail++; $display("FAIL timeout_data_oe got=%b want=0", ps2_data_oe); end
        repeat (3) @(negedge clk);
`endif
        n_checks += 2;
        if (err_cnt - e0 != 1) begin n_fail++; $display("FAIL timeout_error_pulses got=%0d want=1", err_cnt - e0); end
        if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL timeout_ready got=%b want=1", tx_ready); end
    endtask

    task automatic test_reset_mid;
        logic [10:0] obs;
        int inh, d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        send_byte(8'hED, 1'b0);
        device_frame(1'b0, 3, obs, inh);
        dev_clk_low = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL midreset_busy_before got=%b want=1", busy); end
        rst_n = 1'b0;
        #1;
        n_checks += 3;
        if (ps2_clk_oe !== 1'b0)  begin n_fail++; $display("FAIL midreset_clk_oe got=%b want=0", ps2_clk_oe); end
        if (ps2_data_oe !== 1'b0) begin n_fail++; $display("FAIL midreset_data_oe got=%b want=0", ps2_data_oe); end
        if (busy !== 1'b0)        begin n_fail++; $display("FAIL midreset_busy got=%b want=0", busy); end
        dev_clk_low = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        n_checks += 2;
        if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_ready got=%b want=1", tx_ready); end
        if (done_cnt != d0 || err_cnt != e0) begin
            n_fail++; $display("FAIL midreset_pulses got=%0d/%0d want=0/0", done_cnt - d0, err_cnt - e0);
        end
        test_ack(8'hED);
    endtask

    task automatic test_back_to_back;
        logic [10:0] obs, exp;
        int inh, n;
        send_byte(8'hED, 1'b1);
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        device_frame(1'b1, 11, obs, inh);
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 11'h7ff;
        n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL b2b_first_frame got=%b want=%b", obs, exp); end
        n = 0;
        while (!done && n < 300) begin @(negedge clk); n++; end
        n_checks++;
        if (!(done === 1'b1 && tx_ready === 1'b1)) begin
            n_fail++; $display("FAIL b2b_done_ready got=%b%b want=11", done, tx_ready);
        end
        exp_q.push_back(frame_of(8'h55));
        @(negedge clk);
        tx_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_second_accept got=%b want=1", busy); end
        device_frame(1'b1, 11, obs, inh);
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 11'h7ff;
        n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL b2b_second_frame got=%b want=%b", obs, exp); end
        n = 0;
        while (!done && n < 300) begin @(negedge clk); n++; end
        n_checks++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_second_done got=%b want=1", done); end
        repeat (5) @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_ack(8'hED);
        n_checks++;
        if (frame_of(8'hED) !== 11'b1_1_11101101_0) begin n_fail++; $display("FAIL ed_parity_model got=%b", frame_of(8'hED)); end
        test_ack(8'hF4);
        test_nak;
        test_timeout;
        test_reset_mid;
        test_back_to_back;
        n_checks += 2;
        if (both_cnt != 0)     begin n_fail++; $display("FAIL done_error_overlap got=%0d want=0", both_cnt); end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ps2_tx.md
Name: ps2_tx

Overview:
- PS/2 host-to-device transmitter. It sends command bytes from the io_bridge to the keyboard, for example 0xED to set the LEDs or 0xFF to reset the keyboard.
- It is the opposite direction of the existing PS/2 receive path and shares the same ps2_clk/ps2_data lines.
- It drives the lines open-drain through output enables. While busy is high, the PS/2 receiver ignores line activity.

Parameters:
- INHIBIT_CYCLES, 5000: clk cycles that ps2_clk is held low before the start bit (100 us at 50 MHz).
- TIMEOUT_CYCLES, 750000: maximum clk cycles spent waiting for any single device clock edge or for bus release (15 ms at 50 MHz).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tx_data  in  8  command byte
- tx_valid  in  1  request to send tx_data
- tx_ready  out  1  high when idle; the byte is accepted on the cycle where tx_valid && tx_ready
- busy  out  1  high from accept until done or error
- done  out  1  one-cycle pulse: byte sent and ACK seen
- error  out  1  one-cycle pulse: NAK or timeout
- ps2_clk_in  in  1  raw ps2_clk line level (asynchronous)
- ps2_data_in  in  1  raw ps2_data line level (asynchronous)
- ps2_clk_oe  out  1  1 = drive ps2_clk low; 0 = release
- ps2_data_oe  out  1  1 = drive ps2_data low; 0 = release

Behaviour:
- Reset values: tx_ready=1, busy=0, done=0, error=0, ps2_clk_oe=0, ps2_data_oe=0, state=IDLE, all counters 0.
  - Reset is asynchronous. Asserting it mid-transfer releases both lines immediately and drops the transfer; no done or error pulse is produced.
- Input sync: ps2_clk_in and ps2_data_in each pass through a 2-flop synchronizer. A falling edge ("fe") is sync_clk going 1 to 0 between consecutive cycles.
- Accept:
  - Latch tx_data into a shift register.
  - Compute parity = ~^tx_data (odd parity).
  - Set bitcnt=0 and go to INHIBIT. tx_ready drops and busy rises on the following cycle.
- INHIBIT: ps2_clk_oe=1, ps2_data_oe=0 for exactly INHIBIT_CYCLES cycles. Then go to START.
- START:
  - Set ps2_data_oe=1 (start bit 0) and ps2_clk_oe=0 on the same cycle.
  - Wait for fe. On fe, drive bit0 and go to DATA.
- DATA:
  - On each fe, drive the next bit, LSB first. Drive low when the bit is 0 (ps2_data_oe = ~bit).
  - After the fe that follows bit7, drive parity and go to PARITY.
- PARITY: on fe, release data (stop bit) and go to STOP.
- STOP: on fe, sample sync_data and go to WAIT_IDLE.
  - sync_data=0 means ACK.
  - sync_data=1 means NAK; record it.
- WAIT_IDLE:
  - Wait until sync_clk=1 and sync_data=1.
  - Then pulse done (ACK case) or error (NAK case) for one cycle and return to IDLE.
- Timeout:
  - The counter resets on entry to START and on every fe.
  - If it reaches TIMEOUT_CYCLES in START, DATA, PARITY, STOP or WAIT_IDLE: release both lines, pulse error, go to IDLE.
- Data changes only after fe, i.e. while the device holds the clock low. The device samples on the rising edge.
- tx_valid is ignored while busy. No queueing.
- done and error are never asserted together.

Optional Feature:
- PS2_TX_RETRY_EN
  - Defined: on NAK or timeout the transmitter silently restarts from INHIBIT with the same byte, up to 2 retries (3 attempts in total).
    - error pulses only after the third failure.
    - busy stays high across retries.
    - Any ACK ends the sequence with done.
  - Undefined: the first NAK or timeout pulses error immediately.

Test Plan:
- Send 0xED, INHIBIT_CYCLES=100, device model ACKs:
  - ps2_clk_oe high for exactly 100 cycles.
  - Data bits observed at device rising edges: 0 (start), 1,0,1,1,0,1,1,1, parity=1, stop=1.
  - One done pulse; tx_ready returns to 1.
- Send 0xF4, device ACKs -> data bits 0,0,1,0,1,1,1,1, parity=0; done pulse; no error.
- Send 0xFF, device answers NAK (data high at ACK clock) -> single error pulse after the bus goes idle; no done.
  - With PS2_TX_RETRY_EN: 3 complete frames observed, then error.
- TIMEOUT_CYCLES=1000, device never clocks after inhibit -> error pulses exactly 1000 cycles after START entry; both oe outputs 0.
- rst_n pulled low during DATA after the 4th fe -> ps2_clk_oe=ps2_data_oe=0 in the same cycle; no done or error pulse.
  - After release, tx_ready=1 and a new 0xED transfer completes normally.
- tx_valid held high with 0x55 while busy during an 0xED transfer -> only 0xED is sent.
  - 0x55 is accepted on the first cycle tx_ready=1 after done.
